// File: rtl/nios_sys_pio_write_arbiter.sv
// Two-requester round-robin arbiter feeding single-cycle Avalon-MM writes to the
// nios_sys output PIO, with a programmable hold-off after every write.
module nios_sys_pio_write_arbiter #(
  parameter int DATA_W      = 4,
  parameter int HOLD_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              pio_chipselect,
  output logic              pio_write_n,
  output logic [1:0]        pio_address,
  output logic [31:0]       pio_writedata,
  output logic              busy,
  output logic              last_grant
);

  localparam logic [15:0] HOLD_LOAD = 16'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [DATA_W-1:0]   r_data_q;
  logic                r_last_grant;
  logic [15:0]         r_hold_cnt;
  logic                w_idle;
  logic                w_win1;
  logic                w_accept0;
  logic                w_accept1;
  logic [31:0]         w_wdata;

  // Requester 1 wins if it is alone, or if both ask and requester 0 went last.
  assign w_idle    = (r_state == S_IDLE) && !reset;
  assign w_win1    = req1_valid && (!req0_valid || !r_last_grant);
  assign req0_ready = w_idle && req0_valid && !w_win1;
  assign req1_ready = w_idle && w_win1;
  assign w_accept0 = req0_valid && req0_ready;
  assign w_accept1 = req1_valid && req1_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept0 || w_accept1) begin
          w_next_state = S_WRITE;
        end
      end
      S_WRITE: begin
        w_next_state = S_HOLD;
      end
      S_HOLD: begin
        if (r_hold_cnt == 16'd0) begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data_q     <= '0;
      r_last_grant <= 1'b1;
      r_hold_cnt   <= 16'd0;
    end else begin
      if (w_accept1) begin
        r_data_q     <= req1_data;
        r_last_grant <= 1'b1;
      end else if (w_accept0) begin
        r_data_q     <= req0_data;
        r_last_grant <= 1'b0;
      end
      if (r_state == S_WRITE) begin
        r_hold_cnt <= HOLD_LOAD;
      end else if ((r_state == S_HOLD) && (r_hold_cnt != 16'd0)) begin
        r_hold_cnt <= r_hold_cnt - 16'd1;
      end
    end
  end

  // data_q only changes on an accept, which is always followed by WRITE, so
  // driving it continuously gives "last written value" outside WRITE.
  always_comb begin
    w_wdata               = '0;
    w_wdata[DATA_W-1:0]   = r_data_q;
  end

  assign pio_chipselect = (r_state == S_WRITE);
  assign pio_write_n    = (r_state != S_WRITE);
  assign pio_address    = 2'd0;
  assign pio_writedata  = w_wdata;
  assign busy           = (r_state != S_IDLE);
  assign last_grant     = r_last_grant;

endmodule

// File: tb/tb_nios_sys_pio_write_arbiter.sv
// Directed vector bench for nios_sys_pio_write_arbiter (HOLD_CYCLES=4 and =1).
module tb_nios_sys_pio_write_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, req0_valid, req1_valid;
  logic [3:0]  req0_data, req1_data;
  logic        req0_ready, req1_ready, pio_chipselect, pio_write_n, busy, last_grant;
  logic [1:0]  pio_address;
  logic [31:0] pio_writedata;

  logic        b_reset, b_req0_valid, b_req1_valid;
  logic [3:0]  b_req0_data, b_req1_data;
  logic        b_req0_ready, b_req1_ready, b_cs, b_wn, b_busy, b_last_grant;
  logic [1:0]  b_address;
  logic [31:0] b_writedata;

  nios_sys_pio_write_arbiter #(.DATA_W(4), .HOLD_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .pio_chipselect(pio_chipselect), .pio_write_n(pio_write_n),
    .pio_address(pio_address), .pio_writedata(pio_writedata),
    .busy(busy), .last_grant(last_grant)
  );

  nios_sys_pio_write_arbiter #(.DATA_W(4), .HOLD_CYCLES(1)) dut_h1 (
    .clk(clk), .reset(b_reset),
    .req0_valid(b_req0_valid), .req0_data(b_req0_data), .req0_ready(b_req0_ready),
    .req1_valid(b_req1_valid), .req1_data(b_req1_data), .req1_ready(b_req1_ready),
    .pio_chipselect(b_cs), .pio_write_n(b_wn),
    .pio_address(b_address), .pio_writedata(b_writedata),
    .busy(b_busy), .last_grant(b_last_grant)
  );

  typedef struct {
    logic        rst;
    logic        v0;
    logic [3:0]  d0;
    logic        v1;
    logic [3:0]  d1;
    logic        r0;
    logic        r1;
    logic        cs;
    logic        wn;
    logic [31:0] wd;
    logic        bsy;
    logic        lg;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;
  int   wcount = 0;

  always @(negedge clk) begin
    if (pio_chipselect && !pio_write_n) wcount++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic v0, input logic [3:0] d0,
                     input logic v1, input logic [3:0] d1,
                     input logic r0, input logic r1, input logic cs, input logic wn,
                     input logic [31:0] wd, input logic bsy, input logic lg,
                     input int n = 1);
    vec_t v;
    v = '{rst, v0, d0, v1, d1, r0, r1, cs, wn, wd, bsy, lg};
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endtask

  task automatic drive(input logic rst, input logic v0, input logic [3:0] d0,
                       input logic v1, input logic [3:0] d1);
    reset = rst; req0_valid = v0; req0_data = d0; req1_valid = v1; req1_data = d1;
  endtask

  int snap;
  int acc_cyc[$];
  int acc_grant[$];

  initial begin
    drive(1'b1, 1'b0, 4'h0, 1'b0, 4'h0);
    b_reset = 1'b1; b_req0_valid = 1'b0; b_req1_valid = 1'b0;
    b_req0_data = 4'h3; b_req1_data = 4'h5;

    //   rst v0 d0   v1 d1   r0 r1 cs wn wd     bsy lg  n
    add(1, 0, 4'h0, 0, 4'h0, 0, 0, 0, 1, 32'h0, 0, 1);
    add(0, 1, 4'hA, 0, 4'h0, 1, 0, 0, 1, 32'h0, 0, 1);
    add(0, 0, 4'h0, 0, 4'h0, 0, 0, 1, 0, 32'hA, 1, 0);
    add(0, 0, 4'h0, 0, 4'h0, 0, 0, 0, 1, 32'hA, 1, 0, 4);
    add(0, 0, 4'h0, 0, 4'h0, 0, 0, 0, 1, 32'hA, 0, 0);
    add(1, 1, 4'h3, 1, 4'h5, 0, 0, 0, 1, 32'h0, 0, 1);
    add(0, 1, 4'h3, 1, 4'h5, 1, 0, 0, 1, 32'h0, 0, 1);
    add(0, 1, 4'h3, 1, 4'h5, 0, 0, 1, 0, 32'h3, 1, 0);
    add(0, 1, 4'h3, 1, 4'h5, 0, 0, 0, 1, 32'h3, 1, 0, 4);
    add(0, 1, 4'h3, 1, 4'h5, 0, 1, 0, 1, 32'h3, 0, 0);
    add(0, 1, 4'h3, 1, 4'h5, 0, 0, 1, 0, 32'h5, 1, 1);
    add(0, 1, 4'h3, 1, 4'h5, 0, 0, 0, 1, 32'h5, 1, 1, 4);
    add(0, 1, 4'h3, 1, 4'h5, 1, 0, 0, 1, 32'h5, 0, 1);
    add(0, 1, 4'h3, 1, 4'h5, 0, 0, 1, 0, 32'h3, 1, 0);
    add(0, 1, 4'h3, 1, 4'h5, 0, 0, 0, 1, 32'h3, 1, 0, 4);
    add(0, 1, 4'h3, 1, 4'h5, 0, 1, 0, 1, 32'h3, 0, 0);
    add(0, 0, 4'h0, 0, 4'h0, 0, 0, 1, 0, 32'h5, 1, 1);
    add(0, 0, 4'h0, 0, 4'h0, 0, 0, 0, 1, 32'h5, 1, 1);
    add(0, 1, 4'h7, 0, 4'h0, 0, 0, 0, 1, 32'h5, 1, 1);
    add(0, 0, 4'h0, 0, 4'h0, 0, 0, 0, 1, 32'h5, 1, 1, 2);
    add(0, 0, 4'h0, 0, 4'h0, 0, 0, 0, 1, 32'h5, 0, 1);
    add(0, 0, 4'h0, 1, 4'h1, 0, 1, 0, 1, 32'h5, 0, 1);
    add(0, 0, 4'h0, 1, 4'h2, 0, 0, 1, 0, 32'h1, 1, 1);
    add(0, 0, 4'h0, 1, 4'h2, 0, 0, 0, 1, 32'h1, 1, 1, 4);
    add(0, 0, 4'h0, 1, 4'h2, 0, 1, 0, 1, 32'h1, 0, 1);
    add(0, 0, 4'h0, 1, 4'h3, 0, 0, 1, 0, 32'h2, 1, 1);
    add(0, 0, 4'h0, 1, 4'h3, 0, 0, 0, 1, 32'h2, 1, 1, 4);
    add(0, 0, 4'h0, 1, 4'h3, 0, 1, 0, 1, 32'h2, 0, 1);
    add(0, 0, 4'h0, 0, 4'h0, 0, 0, 1, 0, 32'h3, 1, 1);
    add(0, 0, 4'h0, 0, 4'h0, 0, 0, 0, 1, 32'h3, 1, 1, 4);
    add(0, 0, 4'h0, 0, 4'h0, 0, 0, 0, 1, 32'h3, 0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].v0, vecs[i].d0, vecs[i].v1, vecs[i].d1);
      #2;
      chk($sformatf("v%0d.req0_ready", i), 32'(req0_ready), 32'(vecs[i].r0));
      chk($sformatf("v%0d.req1_ready", i), 32'(req1_ready), 32'(vecs[i].r1));
      chk($sformatf("v%0d.chipselect", i), 32'(pio_chipselect), 32'(vecs[i].cs));
      chk($sformatf("v%0d.write_n", i), 32'(pio_write_n), 32'(vecs[i].wn));
      chk($sformatf("v%0d.address", i), 32'(pio_address), 32'd0);
      chk($sformatf("v%0d.writedata", i), pio_writedata, vecs[i].wd);
      chk($sformatf("v%0d.busy", i), 32'(busy), 32'(vecs[i].bsy));
      chk($sformatf("v%0d.last_grant", i), 32'(last_grant), 32'(vecs[i].lg));
    end

    // Reset pulsed mid-HOLD: async clear, then exactly one write for the next request.
    @(negedge clk); drive(0, 1, 4'h9, 0, 4'h0);
    #2 chk("midhold.accept", 32'(req0_ready), 32'd1);
    @(negedge clk); drive(0, 0, 4'h0, 0, 4'h0);
    @(negedge clk);
    #2 chk("midhold.busy_before", 32'(busy), 32'd1);
    chk("midhold.grant_before", 32'(last_grant), 32'd0);
    reset = 1'b1;
    #1 chk("midhold.busy_async", 32'(busy), 32'd0);
    chk("midhold.grant_async", 32'(last_grant), 32'd1);
    chk("midhold.wdata_async", pio_writedata, 32'd0);
    @(negedge clk); drive(0, 0, 4'h0, 1, 4'h6);
    snap = wcount;
    #2 chk("midhold.first_accept", 32'(req1_ready), 32'd1);
    @(negedge clk); drive(0, 0, 4'h0, 0, 4'h0);
    #2 chk("midhold.write_data", pio_writedata, 32'h6);
    repeat (10) @(negedge clk);
    chk("midhold.one_write", 32'(wcount - snap), 32'd1);

    // Reset during WRITE drops chipselect at once and nothing is re-issued.
    @(negedge clk); drive(0, 1, 4'hC, 0, 4'h0);
    @(negedge clk); drive(0, 0, 4'h0, 0, 4'h0);
    #2 chk("midwrite.cs_before", 32'(pio_chipselect), 32'd1);
    reset = 1'b1;
    #1 chk("midwrite.cs_async", 32'(pio_chipselect), 32'd0);
    chk("midwrite.wn_async", 32'(pio_write_n), 32'd1);
    @(negedge clk); reset = 1'b0;
    snap = wcount;
    repeat (8) @(negedge clk);
    chk("midwrite.no_reissue", 32'(wcount - snap), 32'd0);
    #2 chk("midwrite.idle", 32'(busy), 32'd0);

    // HOLD_CYCLES=1 under continuous contention: accepts 3 cycles apart, alternating.
    @(negedge clk);
    b_reset = 1'b0; b_req0_valid = 1'b1; b_req1_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (c != 0) @(negedge clk);
      #2;
      if (b_req0_valid && b_req0_ready) begin acc_cyc.push_back(c); acc_grant.push_back(0); end
      if (b_req1_valid && b_req1_ready) begin acc_cyc.push_back(c); acc_grant.push_back(1); end
    end
    b_req0_valid = 1'b0; b_req1_valid = 1'b0;
    chk("h1.accept_count", 32'(acc_cyc.size()), 32'd4);
    for (int k = 0; k < acc_cyc.size() && k < 4; k++) begin
      chk($sformatf("h1.accept%0d_cycle", k), 32'(acc_cyc[k]), 32'(3 * k));
      chk($sformatf("h1.accept%0d_grant", k), 32'(acc_grant[k]), 32'(k % 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
